// File: rtl/xcore_if_bpu_pkg.sv
// Shared fetch-side parameters and 2-bit branch counter encodings for the BPU.
package xcore_if_bpu_pkg;

  localparam int LEN   = 32;
  localparam int WIDTH = LEN;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  // Saturating step of a 2-bit counter toward the resolved outcome.
  function automatic bht_cnt_e cnt_step(input bht_cnt_e cnt, input logic taken);
    bht_cnt_e nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = bht_cnt_e'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = bht_cnt_e'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/xcore_if_bpu_bht.sv
// Branch history table of 2-bit counters: combinational read, synchronous saturating update.
// Latency: read 0 cycles, write visible next cycle; no backpressure (always accepts).
module xcore_if_bpu_bht
  import xcore_if_bpu_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_cnt_e         o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  bht_cnt_e cnt_q [DEPTH];

  assign o_rd_cnt = cnt_q[i_rd_idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= WNT;
      end
    end else if (i_wr_en) begin
      cnt_q[i_wr_idx] <= cnt_step(cnt_q[i_wr_idx], i_wr_taken);
    end
  end

endmodule

// File: rtl/xcore_if_bpu.sv
// Fetch-stage branch predictor: BHT for branches, adder for jal, one-entry target cache for jalr.
// Latency: prediction 0 cycles, EX updates visible next cycle; no backpressure (always accepts).
module xcore_if_bpu
  import xcore_if_bpu_pkg::*;
#(
  parameter int LEN       = xcore_if_bpu_pkg::LEN,
  parameter int BHT_IDX_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [LEN-1:0] i_pc,
  input  logic           i_pc_instr_vld,
  input  logic           i_mdec_b,
  input  logic           i_mdec_jal,
  input  logic           i_mdec_jalr,
  input  logic [LEN-1:0] i_mdec_b_ofs,
  input  logic [LEN-1:0] i_mdec_jal_ofs,
  input  logic           i_mdec_instr_vld,
  input  logic           i_ex_upd_vld,
  input  logic [LEN-1:0] i_ex_upd_pc,
  input  logic           i_ex_upd_is_b,
  input  logic           i_ex_upd_is_jalr,
  input  logic           i_ex_upd_taken,
  input  logic [LEN-1:0] i_ex_upd_target,
  input  logic           i_ex_upd_mispred,
  output logic           o_bpu_taken,
  output logic [LEN-1:0] o_bpu_target,
  output logic           o_bpu_jalr_hit,
  output logic [15:0]    o_bpu_mispred_cnt
);

  bht_cnt_e       bht_rd_cnt;
  logic [1:0]     bht_rd_bits;
  logic           jalr_vld;
  logic [LEN-1:0] jalr_tag;
  logic [LEN-1:0] jalr_tgt;
  logic [15:0]    mispred_cnt;
  logic [LEN-1:0] b_tgt;
  logic [LEN-1:0] jal_tgt;
  logic           pred_en;

  xcore_if_bpu_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rd_idx   (i_pc[BHT_IDX_W+1:2]),
    .o_rd_cnt   (bht_rd_cnt),
    .i_wr_en    (i_ex_upd_vld & i_ex_upd_is_b),
    .i_wr_idx   (i_ex_upd_pc[BHT_IDX_W+1:2]),
    .i_wr_taken (i_ex_upd_taken)
  );

  assign bht_rd_bits = bht_rd_cnt;
  assign b_tgt       = i_pc + i_mdec_b_ofs;
  assign jal_tgt     = i_pc + i_mdec_jal_ofs;
  assign pred_en     = i_rst_n & i_pc_instr_vld & i_mdec_instr_vld;

  // Prediction reads only registered state, so a same-cycle update never bypasses.
  always_comb begin
    o_bpu_taken    = 1'b0;
    o_bpu_target   = '0;
    o_bpu_jalr_hit = 1'b0;
    if (pred_en) begin
      if (i_mdec_b) begin
        o_bpu_taken  = bht_rd_bits[1];
        o_bpu_target = b_tgt;
      end else if (i_mdec_jal) begin
        o_bpu_taken  = 1'b1;
        o_bpu_target = jal_tgt;
      end else if (i_mdec_jalr && jalr_vld && (jalr_tag == i_pc)) begin
        o_bpu_taken    = 1'b1;
        o_bpu_target   = jalr_tgt;
        o_bpu_jalr_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      jalr_vld    <= 1'b0;
      jalr_tag    <= '0;
      jalr_tgt    <= '0;
      mispred_cnt <= '0;
    end else if (i_ex_upd_vld) begin
      if (i_ex_upd_is_jalr) begin
        jalr_vld <= 1'b1;
        jalr_tag <= i_ex_upd_pc;
        jalr_tgt <= i_ex_upd_target;
      end
      if (i_ex_upd_mispred && (mispred_cnt != 16'hFFFF)) begin
        mispred_cnt <= mispred_cnt + 16'd1;
      end
    end
  end

  assign o_bpu_mispred_cnt = mispred_cnt;

endmodule

// File: doc/xcore_if_bpu.md
XCORE_IF_BPU -- requirements
Module: Xcore_if_bpu

Interface
REQ-001 SHALL take parameter LEN, default 32: datapath width, matching the shared params LEN/WIDTH.
REQ-002 SHALL take parameter BHT_IDX_W, default 4: BHT index width, giving 2^BHT_IDX_W entries.
REQ-003 SHALL have: i_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have: i_rst_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have: i_pc  in  LEN  fetch PC of the predecoded instruction.
REQ-006 SHALL have: i_pc_instr_vld  in  1  fetch PC valid.
REQ-007 SHALL have: i_mdec_b / i_mdec_jal / i_mdec_jalr  in  1 each  predecode class flags.
REQ-008 SHALL have: i_mdec_b_ofs / i_mdec_jal_ofs  in  LEN each  sign-extended offsets.
REQ-009 SHALL have: i_mdec_instr_vld  in  1  predecoded control-transfer valid.
REQ-010 SHALL have: i_ex_upd_vld  in  1  resolution update strobe from EX.
REQ-011 SHALL have: i_ex_upd_pc  in  LEN  PC of the resolved instruction.
REQ-012 SHALL have: i_ex_upd_is_b / i_ex_upd_is_jalr  in  1 each  resolved class.
REQ-013 SHALL have: i_ex_upd_taken  in  1  branch outcome.
REQ-014 SHALL have: i_ex_upd_target  in  LEN  resolved target.
REQ-015 SHALL have: i_ex_upd_mispred  in  1  EX detected a misprediction.
REQ-016 SHALL have: o_bpu_taken  out  1  redirect fetch.
REQ-017 SHALL have: o_bpu_target  out  LEN  predicted target.
REQ-018 SHALL have: o_bpu_jalr_hit  out  1  jalr predicted from target register.
REQ-019 SHALL have: o_bpu_mispred_cnt  out  16  saturating mispredict count.

Function
REQ-020 Prediction SHALL be combinational from i_pc, the predecode inputs and the current registered state: zero-cycle latency; updates visible from the next cycle.
REQ-021 When i_mdec_instr_vld=0 or i_pc_instr_vld=0, o_bpu_taken, o_bpu_target and o_bpu_jalr_hit SHALL be 0.
REQ-022 BHT index SHALL be pc[BHT_IDX_W+1:2]. Each entry SHALL be a 2-bit counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-023 For a branch (i_mdec_b), o_bpu_taken SHALL equal counter[1], and o_bpu_target SHALL be i_pc+i_mdec_b_ofs modulo 2^LEN.
REQ-024 For jal, o_bpu_taken SHALL be 1 and o_bpu_target SHALL be i_pc+i_mdec_jal_ofs modulo 2^LEN.
REQ-025 For jalr, the block SHALL use a one-entry jalr cache (tag PC, target, valid bit). On valid and tag==i_pc: taken=1, target=cached target, jalr_hit=1. Otherwise all three outputs SHALL be 0.
REQ-026 On i_ex_upd_vld with i_ex_upd_is_b=1, the indexed counter SHALL step +1 if taken, else -1.
REQ-027 Counters SHALL saturate: ST stays ST on taken; SNT stays SNT on not-taken.
REQ-028 On i_ex_upd_vld with i_ex_upd_is_jalr=1, the jalr cache SHALL load tag=i_ex_upd_pc and target=i_ex_upd_target, and set valid=1.
REQ-029 Updates with is_b=is_jalr=0 SHALL leave the BHT and jalr cache unchanged.
REQ-030 Same-cycle prediction and update on the same index or tag: the prediction SHALL use the pre-update value (no bypass).
REQ-031 On i_ex_upd_vld and i_ex_upd_mispred, o_bpu_mispred_cnt SHALL increment by 1 and saturate at 16'hFFFF.
REQ-032 i_ex_upd_* inputs SHALL be ignored while i_ex_upd_vld=0.

Reset
REQ-033 While i_rst_n=0 at a rising edge, all BHT counters SHALL be set to WNT (01), the jalr valid bit cleared, tag and target zeroed, and o_bpu_mispred_cnt zeroed.
REQ-034 Reset SHALL take priority over a simultaneous update. A reset asserted mid-operation SHALL discard all learned state.
REQ-035 While i_rst_n=0, o_bpu_taken, o_bpu_target and o_bpu_jalr_hit SHALL be forced to 0.

Structure
REQ-036 LEN, WIDTH and the counter encodings SNT/WNT/WT/ST SHALL live in the shared params include.
REQ-037 The counter table SHALL be a sub-module Xcore_if_bpu_bht with one combinational read port, one synchronous write port and synchronous reset.

Verification
REQ-038 Reset, then branch at pc=0x100 with ofs=0x20 -> taken=0, target=0x120.
REQ-039 Two taken updates for pc=0x100 -> next predict taken=1. Third and fourth taken updates -> counter stays 11. Four not-taken updates -> 00, taken=0.
REQ-040 jal at pc=0xFFFFFFF0 with ofs=0x20 -> taken=1, target=0x10 (wrap).
REQ-041 jalr at pc=0x200 before update -> taken=0, hit=0. After update with target 0x8000 -> taken=1, hit=1, target=0x8000. After reset -> hit=0.
REQ-042 Same cycle: predict pc=0x100 (counter 01) and taken update for 0x100 -> this cycle taken=0, next cycle taken=1.
REQ-043 Preload cnt=16'hFFFE, then apply 3 mispredict updates -> cnt=16'hFFFF.
